// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory bus; 1-cycle accept, DONE one cycle after MEM_RDY.
// Requesters hold REQ until their DONE pulse; accesses with no MEM_RDY abort after WAIT_MAX busy cycles.
module mem_arbiter #(
    parameter int WAIT_MAX = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_done,
    output logic [15:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [15:0] i_d_addr,
    input  logic [15:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_done,
    output logic [15:0] o_d_rdata,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_rdy,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_IF,
        S_BUSY_D,
        S_DONE_IF,
        S_DONE_D
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      r_state;
    logic        r_last_d;
    logic [7:0]  r_cnt;
    logic        r_if_gnt;
    logic        r_if_done;
    logic [15:0] r_if_rdata;
    logic        r_d_gnt;
    logic        r_d_done;
    logic [15:0] r_d_rdata;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_err;

    logic        w_pick_d;
    logic        w_timeout;

    // On a tie the port that did not win last time goes next.
    assign w_pick_d  = i_d_req & (~i_if_req | ~r_last_d);
    assign w_timeout = (r_cnt == LP_CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_last_d    <= 1'b0;
            r_cnt       <= 8'd0;
            r_if_gnt    <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_rdata  <= 16'h0000;
            r_d_gnt     <= 1'b0;
            r_d_done    <= 1'b0;
            r_d_rdata   <= 16'h0000;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_err       <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_d) begin
                        r_state     <= S_BUSY_D;
                        r_last_d    <= 1'b1;
                        r_cnt       <= 8'd0;
                        r_d_gnt     <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= i_d_we;
                        r_mem_addr  <= i_d_addr;
                        r_mem_wdata <= i_d_wdata;
                    end else if (i_if_req) begin
                        r_state    <= S_BUSY_IF;
                        r_last_d   <= 1'b0;
                        r_cnt      <= 8'd0;
                        r_if_gnt   <= 1'b1;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= i_if_addr;
                    end
                end
                S_BUSY_IF, S_BUSY_D: begin
                    // MEM_RDY wins over a timeout landing on the same edge.
                    if (i_mem_rdy || w_timeout) begin
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_err    <= ~i_mem_rdy;
                        if (r_state == S_BUSY_IF) begin
                            r_state    <= S_DONE_IF;
                            r_if_done  <= 1'b1;
                            r_if_rdata <= i_mem_rdy ? i_mem_rdata : 16'h0000;
                        end else begin
                            r_state  <= S_DONE_D;
                            r_d_done <= 1'b1;
                            if (!i_mem_rdy)
                                r_d_rdata <= 16'h0000;
                            else if (!r_mem_we)
                                r_d_rdata <= i_mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_if_gnt <= 1'b0;
                    r_d_gnt  <= 1'b0;
                end
            endcase
        end
    end

    assign o_if_gnt    = r_if_gnt;
    assign o_if_done   = r_if_done;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_gnt     = r_d_gnt;
    assign o_d_done    = r_d_done;
    assign o_d_rdata   = r_d_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_err       = r_err;

endmodule
